// File: rtl/adder_pkg.sv
// Shared FSM encodings and width helper for the chunk-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for n states; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple adder of full_adder cells; combinational, no flow control.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (c[i]),
            .sum   (sum[i]),
            .c_out (c[i+1])
        );
    end

    assign c_out = c[CHUNK];
    // Carry into the top bit, needed for signed overflow on the last chunk.
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell; purely combinational, no flow control.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle add/sub, CHUNK bits per clock; done pulses WIDTH/CHUNK+1 edges after start.
// No backpressure: start is only honoured in IDLE, ignored while busy or done.
module chunk_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = clog2(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;

    logic [CHUNK-1:0] ch_a;
    logic [CHUNK-1:0] ch_b;
    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout;
    logic             ch_cmsb;

    assign ch_a = op_a[int'(cnt)*CHUNK +: CHUNK];
    assign ch_b = op_b[int'(cnt)*CHUNK +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a     (ch_a),
        .b     (ch_b),
        .c_in  (carry),
        .sum   (ch_sum),
        .c_out (ch_cout),
        .c_msb (ch_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1; c_in=1 as borrow drops the +1.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= c_in ^ sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum[int'(cnt)*CHUNK +: CHUNK] <= ch_sum;
                    carry <= ch_cout;
                    if (cnt == LAST) begin
                        c_out    <= ch_cout;
                        overflow <= ch_cmsb ^ ch_cout;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Bench for chunk_serial_adder: a 32/4 instance and an 8/8 instance against an arithmetic model.
module tb_chunk_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start32, sub32, cin32, busy32, done32, cout32, ov32;
    logic [31:0] a32, b32, sum32;
    logic        start8, sub8, cin8, busy8, done8, cout8, ov8;
    logic [7:0]  a8, b8, sum8;

    int n_checks = 0;
    int n_fail   = 0;

    chunk_serial_adder #(.WIDTH(32), .CHUNK(4)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .sub(sub32), .a(a32), .b(b32), .c_in(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .c_out(cout32), .overflow(ov32)
    );

    chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .c_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .overflow(ov8)
    );

    // Reference: plain w-bit unsigned/signed arithmetic.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin,
                         output logic [31:0] s, output logic co, output logic ov);
        longint mask, half, ua, ub, sa, sb, r, sr, ci;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua = longint'({32'd0, a}) & mask;
        ub = longint'({32'd0, b}) & mask;
        ci = cin ? 1 : 0;
        sa = (ua >= half) ? ua - 2 * half : ua;
        sb = (ub >= half) ? ub - 2 * half : ub;
        if (sub) begin
            r  = ua - ub - ci;
            co = (ua >= ub + ci);
            sr = sa - sb - ci;
        end else begin
            r  = ua + ub + ci;
            co = (r > mask);
            sr = sa + sb + ci;
        end
        s  = 32'(r & mask);
        ov = (sr < -half) || (sr >= half);
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic cin, output int edges, output int busy_cycles);
        @(negedge clk);
        a32 = a; b32 = b; sub32 = sub; cin32 = cin; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom); cin32 = 1'($urandom);
        edges = 1;
        busy_cycles = 0;
        while (done32 !== 1'b1 && edges < 200) begin
            if (busy32 === 1'b1) busy_cycles++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic cin, output int edges, output int busy_cycles);
        @(negedge clk);
        a8 = a; b8 = b; sub8 = sub; cin8 = cin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
        edges = 1;
        busy_cycles = 0;
        while (done8 !== 1'b1 && edges < 200) begin
            if (busy8 === 1'b1) busy_cycles++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if ({busy32, done32, sum32, cout32, ov32} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset32: got busy=%b done=%b sum=%h c_out=%b ov=%b, want all zero",
                     busy32, done32, sum32, cout32, ov32);
        end
        n_checks++;
        if ({busy8, done8, sum8, cout8, ov8} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h c_out=%b ov=%b, want all zero",
                     busy8, done8, sum8, cout8, ov8);
        end
    endtask

    task automatic test_add_carry;
        logic [31:0] es; logic eco, eov; int e, bc;
        model(32, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, es, eco, eov);
        run32(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, e, bc);
        n_checks++;
        if (done32 !== 1'b1 || e != 9) begin
            n_fail++;
            $display("FAIL add_carry_latency: done=%b after %0d cycles, want done=1 after 9", done32, e);
        end
        n_checks++;
        if (bc != 8) begin
            n_fail++;
            $display("FAIL add_carry_busy: busy high %0d cycles, want 8", bc);
        end
        n_checks++;
        if ({sum32, cout32, ov32} !== {es, eco, eov}) begin
            n_fail++;
            $display("FAIL add_carry_result: got %h/%b/%b want %h/%b/%b", sum32, cout32, ov32, es, eco, eov);
        end
        @(negedge clk);
        n_checks++;
        if (done32 !== 1'b0) begin
            n_fail++;
            $display("FAIL add_carry_pulse: done=%b one cycle later, want 0", done32);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] es; logic eco, eov; int e, bc;
        model(32, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, es, eco, eov);
        run32(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, e, bc);
        n_checks++;
        if (done32 !== 1'b1 || {sum32, cout32, ov32} !== {es, eco, eov}) begin
            n_fail++;
            $display("FAIL add_overflow: done=%b got %h/%b/%b want %h/%b/%b",
                     done32, sum32, cout32, ov32, es, eco, eov);
        end
    endtask

    task automatic test_sub;
        logic [31:0] va [3] = '{32'd5, 32'd7, 32'd7};
        logic [31:0] vb [3] = '{32'd7, 32'd5, 32'd5};
        logic        vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] es; logic eco, eov; int e, bc;
        for (int i = 0; i < 3; i++) begin
            model(32, va[i], vb[i], 1'b1, vc[i], es, eco, eov);
            run32(va[i], vb[i], 1'b1, vc[i], e, bc);
            n_checks++;
            if (done32 !== 1'b1 || {sum32, cout32, ov32} !== {es, eco, eov}) begin
                n_fail++;
                $display("FAIL sub_%0d: done=%b got %h/%b/%b want %h/%b/%b",
                         i, done32, sum32, cout32, ov32, es, eco, eov);
            end
        end
    endtask

    task automatic test_ignore_start;
        int pulses; logic [31:0] at_done;
        pulses = 0;
        at_done = '0;
        @(negedge clk);
        a32 = 32'h12345678; b32 = 32'h11111111; sub32 = 1'b0; cin32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (2) @(negedge clk);
        a32 = 32'hDEADBEEF; b32 = 32'hCAFEF00D; sub32 = 1'b1; cin32 = 1'b1; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (done32 === 1'b1) begin
                pulses++;
                at_done = sum32;
            end
            @(negedge clk);
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL ignore_start_pulses: %0d done pulses, want 1", pulses);
        end
        n_checks++;
        if (at_done !== 32'h23456789) begin
            n_fail++;
            $display("FAIL ignore_start_result: got %h want 23456789", at_done);
        end
        n_checks++;
        if (sum32 !== 32'h23456789 || busy32 !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_hold: sum=%h busy=%b want 23456789 busy=0", sum32, busy32);
        end
    endtask

    task automatic test_reset_mid_run;
        int pulses, e, bc;
        pulses = 0;
        @(negedge clk);
        a32 = 32'hFFFF0000; b32 = 32'h00001234; sub32 = 1'b0; cin32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy32 !== 1'b0 || sum32 !== 32'd0 || done32 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: busy=%b sum=%h done=%b want 0/0/0", busy32, sum32, done32);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done32 === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: %0d done pulses, want 0", pulses);
        end
        run32(32'h0000000F, 32'h00000001, 1'b0, 1'b0, e, bc);
        n_checks++;
        if (done32 !== 1'b1 || sum32 !== 32'h00000010 || cout32 !== 1'b0 || ov32 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_then_add: done=%b got %h/%b/%b want 00000010/0/0", done32, sum32, cout32, ov32);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] es; logic eco, eov; int e, bc, waited;
        run32(32'h00000100, 32'h00000200, 1'b0, 1'b0, e, bc);
        // Raise start during the done cycle: the DONE edge must ignore it, the next edge takes it.
        a32 = 32'h80000000; b32 = 32'h00000001; sub32 = 1'b1; cin32 = 1'b0; start32 = 1'b1;
        model(32, 32'h80000000, 32'h1, 1'b1, 1'b0, es, eco, eov);
        @(negedge clk);
        n_checks++;
        if (busy32 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_ignore: busy=%b after DONE edge, want 0", busy32);
        end
        @(negedge clk);
        start32 = 1'b0;
        n_checks++;
        if (busy32 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b after IDLE edge, want 1", busy32);
        end
        waited = 0;
        while (done32 !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (done32 !== 1'b1 || {sum32, cout32, ov32} !== {es, eco, eov}) begin
            n_fail++;
            $display("FAIL b2b_result: done=%b got %h/%b/%b want %h/%b/%b",
                     done32, sum32, cout32, ov32, es, eco, eov);
        end
    endtask

    task automatic test_random;
        logic [31:0] ra, rb, es; logic rs, rc, eco, eov; int e, bc;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom;
            rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            if (i == 0) ra = 32'h0;
            if (i == 1) rb = 32'hFFFFFFFF;
            model(32, ra, rb, rs, rc, es, eco, eov);
            run32(ra, rb, rs, rc, e, bc);
            n_checks++;
            if (done32 !== 1'b1 || e != 9 || {sum32, cout32, ov32} !== {es, eco, eov}) begin
                n_fail++;
                $display("FAIL random32_%0d: %h %s %h c_in=%b done=%b lat=%0d got %h/%b/%b want %h/%b/%b lat=9",
                         i, ra, rs ? "-" : "+", rb, rc, done32, e, sum32, cout32, ov32, es, eco, eov);
            end
        end
    endtask

    task automatic test_full_chunk;
        logic [31:0] es; logic eco, eov; logic [7:0] ra, rb; logic rs, rc; int e, bc;
        model(8, 32'h80, 32'h80, 1'b0, 1'b0, es, eco, eov);
        run8(8'h80, 8'h80, 1'b0, 1'b0, e, bc);
        n_checks++;
        if (done8 !== 1'b1 || e != 2 || bc != 1) begin
            n_fail++;
            $display("FAIL full_chunk_latency: done=%b lat=%0d busy=%0d want 1/2/1", done8, e, bc);
        end
        n_checks++;
        if ({sum8, cout8, ov8} !== {es[7:0], eco, eov}) begin
            n_fail++;
            $display("FAIL full_chunk_result: got %h/%b/%b want %h/%b/%b", sum8, cout8, ov8, es[7:0], eco, eov);
        end
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            model(8, {24'd0, ra}, {24'd0, rb}, rs, rc, es, eco, eov);
            run8(ra, rb, rs, rc, e, bc);
            n_checks++;
            if (done8 !== 1'b1 || {sum8, cout8, ov8} !== {es[7:0], eco, eov}) begin
                n_fail++;
                $display("FAIL random8_%0d: %h %s %h c_in=%b done=%b got %h/%b/%b want %h/%b/%b",
                         i, ra, rs ? "-" : "+", rb, rc, done8, sum8, cout8, ov8, es[7:0], eco, eov);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start32 = 1'b0; sub32 = 1'b0; cin32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        test_add_carry;
        test_overflow;
        test_sub;
        test_ignore_start;
        test_reset_mid_run;
        test_back_to_back;
        test_random;
        test_full_chunk;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
